// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants for the multiplexed 7-segment scanner
package display_pkg;

    localparam int NUM_DIGITS = 8;

    // Active-low segment patterns ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;
    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/display_hex_to_seg.sv
// rtl/display_hex_to_seg.sv - combinational hex nibble to active-low segment decoder
module hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_OFF;
        case (hex)
            4'h0: seg_n = SEG_0;
            4'h1: seg_n = SEG_1;
            4'h2: seg_n = SEG_2;
            4'h3: seg_n = SEG_3;
            4'h4: seg_n = SEG_4;
            4'h5: seg_n = SEG_5;
            4'h6: seg_n = SEG_6;
            4'h7: seg_n = SEG_7;
            4'h8: seg_n = SEG_8;
            4'h9: seg_n = SEG_9;
            4'hA: seg_n = SEG_A;
            4'hB: seg_n = SEG_B;
            4'hC: seg_n = SEG_C;
            4'hD: seg_n = SEG_D;
            4'hE: seg_n = SEG_E;
            4'hF: seg_n = SEG_F;
            default: seg_n = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// rtl/display_scan.sv - 8-digit hex display scanner with snapshot, freeze and zero blanking
module display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int ZERO_BLANK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] display_syscall,
    input  logic [14:0] display_pc,
    input  logic        mode_sel,
    input  logic        freeze,
    output logic [6:0]  seg_n,
    output logic [7:0]  an_n,
    output logic        dp_n
);

    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  digit_q, digit_d;
    logic [31:0] snap_q, snap_d;
    logic        mode_q, mode_d;
    logic        init_q, init_d;
    logic [6:0]  seg_q, seg_d;
    logic [7:0]  an_q, an_d;
    logic        dp_q, dp_d;

    logic        tick;
    logic [31:0] src;
    logic [31:0] shifted;
    logic        blank;
    logic [6:0]  seg_dec;

    assign tick = (cnt_q == 16'(SCAN_DIV - 1));
    assign src  = mode_sel ? {17'b0, display_pc} : display_syscall;

    // Outputs are built from next-state values so the new digit and its
    // snapshot land together on the same edge, keeping each frame coherent.
    always_comb begin
        cnt_d   = tick ? 16'd0 : cnt_q + 16'd1;
        digit_d = tick ? digit_q + 3'd1 : digit_q;
        mode_d  = mode_sel;
        init_d  = 1'b0;
        snap_d  = snap_q;
        if (init_q) begin
            snap_d = src;
        end else if (!freeze && ((tick && digit_q == 3'd7) || (mode_sel != mode_q))) begin
            snap_d = src;
        end

        shifted = snap_d >> {digit_d, 2'b00};
        blank   = (ZERO_BLANK != 0) && (digit_d != 3'd0) && (shifted == 32'd0);

        an_d  = blank ? 8'hFF : ~(8'b1 << digit_d);
        seg_d = blank ? SEG_OFF : seg_dec;
        dp_d  = !((digit_d == 3'd0) && mode_d);
    end

    hex_to_seg u_hex_to_seg (
        .hex   (shifted[3:0]),
        .seg_n (seg_dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= 16'd0;
            digit_q <= 3'd0;
            snap_q  <= 32'd0;
            mode_q  <= 1'b0;
            init_q  <= 1'b1;
            seg_q   <= SEG_OFF;
            an_q    <= 8'hFF;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            snap_q  <= snap_d;
            mode_q  <= mode_d;
            init_q  <= init_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
        end
    end

    assign seg_n = seg_q;
    assign an_n  = an_q;
    assign dp_n  = dp_q;

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - scoreboard bench for display_scan with SCAN_DIV=4
module tb_display_scan;

    localparam int DIV = 4;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] display_syscall = 32'd0;
    logic [14:0] display_pc = 15'd0;
    logic        mode_sel = 1'b0;
    logic        freeze = 1'b0;
    logic [6:0]  seg_n;
    logic [7:0]  an_n;
    logic        dp_n;

    int tests_run = 0;
    int tests_failed = 0;
    exp_t sb[$];

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    display_scan #(.SCAN_DIV(DIV), .ZERO_BLANK(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .display_syscall (display_syscall),
        .display_pc      (display_pc),
        .mode_sel        (mode_sel),
        .freeze          (freeze),
        .seg_n           (seg_n),
        .an_n            (an_n),
        .dp_n            (dp_n)
    );

    always #5 clk = ~clk;

    function automatic exp_t expect_digit(input logic [31:0] value, input int d, input logic mode);
        exp_t e;
        logic [31:0] sh;
        logic        blank;
        sh = value >> (4 * d);
        blank = (d != 0) && (sh == 32'd0);
        e.an  = blank ? 8'hFF : ~(8'h01 << d);
        e.seg = blank ? 7'h7F : seg_tab[sh[3:0]];
        e.dp  = (d == 0 && mode) ? 1'b0 : 1'b1;
        return e;
    endfunction

    // Called just after a frame-boundary edge; consumes exactly one frame.
    task automatic check_frame(input logic [31:0] value, input logic mode, input string name);
        exp_t e;
        for (int d = 0; d < 8; d++) sb.push_back(expect_digit(value, d, mode));
        for (int d = 0; d < 8; d++) begin
            e = sb.pop_front();
            for (int c = 0; c < DIV; c++) begin
                tests_run++;
                if ({an_n, seg_n, dp_n} !== e) begin
                    tests_failed++;
                    $display("FAIL %s digit %0d cycle %0d: an_n=%h seg_n=%b dp_n=%b expected an_n=%h seg_n=%b dp_n=%b",
                             name, d, c, an_n, seg_n, dp_n, e.an, e.seg, e.dp);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic check_outputs_off(input string name);
        tests_run++;
        if (an_n !== 8'hFF || seg_n !== 7'h7F || dp_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s: an_n=%h seg_n=%h dp_n=%b expected an_n=ff seg_n=7f dp_n=1",
                     name, an_n, seg_n, dp_n);
        end
    endtask

    task automatic release_and_align();
        @(negedge clk);
        rst = 1'b0;
        repeat (32) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        display_syscall = 32'h1234ABCD;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_off("reset_state");
        release_and_align();
    endtask

    task automatic test_basic();
        check_frame(32'h1234ABCD, 1'b0, "basic_1234abcd");
    endtask

    task automatic test_blank_f5();
        display_syscall = 32'h000000F5;
        check_frame(32'h1234ABCD, 1'b0, "hold_until_boundary");
        check_frame(32'h000000F5, 1'b0, "blank_f5");
    endtask

    task automatic test_zero();
        display_syscall = 32'h00000000;
        check_frame(32'h000000F5, 1'b0, "hold_f5");
        check_frame(32'h00000000, 1'b0, "all_zero");
    endtask

    task automatic test_mode_toggle();
        repeat (9) @(posedge clk);
        #1;
        display_pc = 15'h7FFF;
        mode_sel = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (an_n !== 8'hFB || seg_n !== 7'b0001110 || dp_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL mode_toggle_midframe: an_n=%h seg_n=%b dp_n=%b expected an_n=fb seg_n=0001110 dp_n=1",
                     an_n, seg_n, dp_n);
        end
        repeat (22) @(posedge clk);
        #1;
        check_frame(32'h00007FFF, 1'b1, "pc_mode_frame");
        display_syscall = 32'h00C0FFEE;
        mode_sel = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (an_n !== 8'hFE || seg_n !== 7'b0000110 || dp_n !== 1'b1) begin
            tests_failed++;
            $display("FAIL mode_back_to_syscall: an_n=%h seg_n=%b dp_n=%b expected an_n=fe seg_n=0000110 dp_n=1",
                     an_n, seg_n, dp_n);
        end
        repeat (31) @(posedge clk);
        #1;
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        display_syscall = 32'h11111111;
        check_frame(32'h00C0FFEE, 1'b0, "freeze_frame1");
        display_syscall = 32'h22222222;
        check_frame(32'h00C0FFEE, 1'b0, "freeze_frame2");
        display_syscall = 32'h33333333;
        check_frame(32'h00C0FFEE, 1'b0, "freeze_frame3");
        freeze = 1'b0;
        check_frame(32'h00C0FFEE, 1'b0, "unfreeze_wait");
        check_frame(32'h33333333, 1'b0, "unfreeze_new");
    endtask

    task automatic test_async_reset();
        repeat (5) @(posedge clk);
        #2;
        display_syscall = 32'h0000BEEF;
        freeze = 1'b1;
        rst = 1'b1;
        #1;
        check_outputs_off("async_reset_immediate");
        release_and_align();
        check_frame(32'h0000BEEF, 1'b0, "restart_after_reset");
        freeze = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blank_f5();
        test_zero();
        test_mode_toggle();
        test_freeze();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each digit is lit (legal range 2..65535).
REQ-002 SHALL have parameter ZERO_BLANK, default 1, meaning leading-zero digit blanking is enabled.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 display_syscall  input  32  syscall value driven by the CPU.
REQ-006 display_pc  input  15  program-counter display value driven by the CPU.
REQ-007 mode_sel  input  1  source select: 0 = syscall value, 1 = PC.
REQ-008 freeze  input  1  when high, the snapshot is held.
REQ-009 seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 an_n  output  8  digit enables, active-low; bit i = hex nibble i (bit 0 = least significant).
REQ-011 dp_n  output  1  decimal point, active-low.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; tick SHALL assert for one cycle when the count equals SCAN_DIV-1.
REQ-013 Digit index (3 bits) SHALL increment on each tick and wrap from 7 to 0.
REQ-014 Source value SHALL be display_syscall when mode_sel=0, else {17'b0, display_pc}.
REQ-015 Snapshot (32 bits) SHALL load the source value on a tick with digit index 7 (frame boundary), unless freeze=1.
REQ-016 Snapshot SHALL also load, regardless of digit index, in the cycle after mode_sel changes, unless freeze=1.
REQ-017 Snapshot SHALL load in the first cycle after rst deasserts, regardless of freeze.
REQ-018 seg_n, an_n and dp_n SHALL be registered; the outputs SHALL reflect the new digit index exactly one cycle after the tick.
REQ-019 an_n SHALL be ~(8'b1 << digit), except when the digit is blanked, in which case it SHALL be 8'hFF.
REQ-020 With ZERO_BLANK=1, digit i (i>0) SHALL be blanked when nibbles i..7 of the snapshot are all zero; digit 0 SHALL never be blanked.
REQ-021 seg_n SHALL use the hex encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 dp_n SHALL be 0 only when the digit index is 0 and the registered mode is 1 (PC mode indicator); otherwise it SHALL be 1.
REQ-023 Input changes that do not meet the conditions in REQ-015..REQ-017 SHALL NOT alter the displayed frame; a frame SHALL be internally consistent.

Reset
REQ-024 On rst, the prescaler, digit index and snapshot SHALL clear to 0, and the registered mode SHALL clear to 0.
REQ-025 On rst, outputs SHALL be an_n=8'hFF, seg_n=7'h7F and dp_n=1.
REQ-026 Reset asserted mid-scan SHALL take effect immediately, without waiting for clk.

Structure
REQ-027 Package display_pkg SHALL hold NUM_DIGITS=8, the sixteen SEG_* encodings and the SEG_OFF=7'h7F constant.
REQ-028 Hex-to-segment decoding SHALL be a combinational sub-module hex_to_seg (4-bit in, 7-bit active-low out).

Verification
REQ-029 SCAN_DIV=4, mode_sel=0, display_syscall=32'h1234ABCD after reset -> digits 0..7 show D,C,b,A,4,3,2,1; each digit is lit for 4 cycles; the frame is 32 cycles.
REQ-030 display_syscall=32'h0000_00F5 with ZERO_BLANK=1 -> an_n=8'hFF for digits 2..7; digit 0 shows 5; digit 1 shows F.
REQ-031 display_syscall=0 -> only digit 0 is lit, showing 0 (1000000); all other digits are blanked.
REQ-032 mode_sel toggles 0->1 mid-frame with display_pc=15'h7FFF -> the snapshot is 32'h00007FFF in the next cycle; dp_n=0 on digit 0.
REQ-033 freeze=1, then display_syscall changes across three frames -> the displayed value does not change; after freeze=0, the new value appears at the next frame boundary.
REQ-034 rst pulsed asynchronously mid-digit -> outputs go to FF/7F/1 within the same cycle; the scan restarts at digit 0 with the prescaler at 0.
